// File: rtl/uart_pkg.sv
// Shared state encoding, parity modes and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam int unsigned PAR_NONE      = 0;
  localparam int unsigned PAR_ODD       = 1;
  localparam int unsigned PAR_EVEN      = 2;
  localparam int unsigned MAX_DATA_BITS = 8;

  // XOR reduction of a payload; narrower payloads are zero-extended by the caller.
  function automatic logic data_parity(input logic [MAX_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic first-word-fall-through synchronous FIFO; head is read straight from storage.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // Pop on empty is ignored; push on full only lands if a pop frees the slot this cycle.
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign dout      = mem[rd_ptr];

  // Entry storage; cleared on reset so the head reads zero when nothing was written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_push_c) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with error-tagged receive FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        sys_rstn,
  input  logic                        uart_rxd,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic                        rd_en,
  input  logic                        clr_overrun,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_frame_err,
  output logic                        rd_parity_err,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  output logic                        busy
);

  localparam int unsigned TCNT_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W  = 4;
  localparam int unsigned ENTRY_W = DATA_BITS + 2;

  localparam logic [TCNT_W-1:0] T_HALF      = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] T_LAST      = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] B_DATA_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] B_STOP_LAST = BCNT_W'(STOP_BITS - 1);
  localparam bit                PARITY_EN   = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

  rx_state_e            state;
  logic                 sync1;
  logic                 rx_s;
  logic                 rx_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic [TCNT_W-1:0]    tcnt;
  logic [BCNT_W-1:0]    bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;

  logic                 tick_c;
  logic                 fall_c;
  logic                 start_c;
  logic                 bit_end_c;
  logic                 par_x_c;
  logic                 parity_bad_c;
  logic                 push_c;
  logic [ENTRY_W-1:0]   push_entry_c;
  logic [ENTRY_W-1:0]   head_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;

  // Two-flop synchroniser plus edge-detect history; all idle high out of reset.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uart_rxd;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign fall_c  = rx_prev && !rx_s;
  assign start_c = (state == S_IDLE) && fall_c;
  assign tick_c  = (div_cnt == '0);

  // Oversample tick divider; reloaded on the start edge so bit phase follows the line.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      div_cnt <= '0;
    end else if (start_c || tick_c) begin
      div_cnt <= baud_div;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // After the mid-start sample tcnt restarts, so every later sample lands a full bit later.
  assign bit_end_c = tick_c && (tcnt == T_LAST);

  assign par_x_c      = data_parity(MAX_DATA_BITS'(shreg)) ^ rx_s;
  assign parity_bad_c = (PARITY == PAR_EVEN) ? par_x_c : !par_x_c;

  assign push_c       = (state == S_STOP) && bit_end_c && (bcnt == B_STOP_LAST);
  assign push_entry_c = {par_err, frm_err || !rx_s, shreg};

  // Frame FSM: start validation, LSB-first data, optional parity, stop checks.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fall_c) begin
            state <= S_START;
            tcnt  <= '0;
          end
        end
        S_START: begin
          if (tick_c) begin
            if (tcnt == T_HALF) begin
              tcnt <= '0;
              if (rx_s) begin
                state <= S_IDLE;
              end else begin
                state   <= S_DATA;
                bcnt    <= '0;
                par_err <= 1'b0;
                frm_err <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick_c) begin
            if (tcnt == T_LAST) begin
              tcnt  <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bcnt == B_DATA_LAST) begin
                bcnt  <= '0;
                state <= PARITY_EN ? S_PARITY : S_STOP;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick_c) begin
            if (tcnt == T_LAST) begin
              tcnt    <= '0;
              par_err <= parity_bad_c;
              state   <= S_STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick_c) begin
            if (tcnt == T_LAST) begin
              tcnt <= '0;
              if (!rx_s) begin
                frm_err <= 1'b1;
              end
              if (bcnt == B_STOP_LAST) begin
                bcnt  <= '0;
                state <= S_IDLE;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky overrun: a completed frame met a full FIFO with no pop to make room.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      overrun <= 1'b0;
    end else if (push_c && fifo_full_c && !rd_en) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (sys_rstn),
    .push  (push_c),
    .pop   (rd_en),
    .din   (push_entry_c),
    .dout  (head_c),
    .count (fifo_count),
    .full  (fifo_full_c),
    .empty (fifo_empty_c)
  );

  assign {rd_parity_err, rd_frame_err, rd_data} = head_c;
  assign rd_valid = !fifo_empty_c;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 16;
  localparam int DEPTH    = 4;

  typedef logic [9:0] entry_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] baud_div = '0;

  logic       rxd = 1'b1, rd_en = 1'b0, clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_ferr, rd_perr, rd_valid, overrun, busy;
  logic [2:0] fifo_count;

  logic       rxd_p = 1'b1, rd_en_p = 1'b0, clr_p = 1'b0;
  logic [7:0] rd_data_p;
  logic       rd_ferr_p, rd_perr_p, rd_valid_p, overrun_p, busy_p;
  logic [2:0] fifo_count_p;

  entry_t sb[$];
  entry_t sb_p[$];
  logic   exp_ovr = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_param dut (
    .clk_in(clk), .sys_rstn(rst_n), .uart_rxd(rxd), .baud_div(baud_div),
    .rd_en(rd_en), .clr_overrun(clr), .rd_data(rd_data), .rd_frame_err(rd_ferr),
    .rd_parity_err(rd_perr), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_param #(.PARITY(2)) dut_p (
    .clk_in(clk), .sys_rstn(rst_n), .uart_rxd(rxd_p), .baud_div(baud_div),
    .rd_en(rd_en_p), .clr_overrun(clr_p), .rd_data(rd_data_p), .rd_frame_err(rd_ferr_p),
    .rd_parity_err(rd_perr_p), .rd_valid(rd_valid_p), .fifo_count(fifo_count_p),
    .overrun(overrun_p), .busy(busy_p)
  );

  task automatic set_line(input bit par_line, input logic v);
    if (par_line) rxd_p = v;
    else rxd = v;
  endtask

  task automatic drive_bit(input bit par_line, input logic v);
    set_line(par_line, v);
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Expected entry: even-parity error for the parity instance, dropped when the model FIFO is full.
  task automatic expect_frame(input bit par_line, input logic [7:0] d, input logic pbit,
                              input logic ferr);
    entry_t e;
    if (par_line) begin
      e = {^{d, pbit}, ferr, d};
      if (sb_p.size() < DEPTH) sb_p.push_back(e);
    end else begin
      e = {1'b0, ferr, d};
      if (sb.size() < DEPTH) sb.push_back(e);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic frame_head(input bit par_line, input logic [7:0] d, input logic pbit);
    drive_bit(par_line, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(par_line, d[i]);
    if (par_line) drive_bit(par_line, pbit);
  endtask

  task automatic drive_stop(input bit par_line, input int low_clks);
    if (low_clks > 0) begin
      set_line(par_line, 1'b0);
      repeat (low_clks) @(posedge clk);
      #1;
    end
    set_line(par_line, 1'b1);
    repeat (BIT_CLKS - low_clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit par_line, input logic [7:0] d, input logic pbit,
                            input int low_clks);
    expect_frame(par_line, d, pbit, low_clks > 0);
    frame_head(par_line, d, pbit);
    drive_stop(par_line, low_clks);
  endtask

  task automatic pop_main();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic pop_par();
    @(posedge clk); #1 rd_en_p = 1'b1;
    @(posedge clk); #1 rd_en_p = 1'b0;
  endtask

  task automatic wait_valid(input bit par_line, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = par_line ? rd_valid_p : rd_valid;
    end
  endtask

  function automatic entry_t take(input bit par_line);
    entry_t e = '1;
    if (par_line) begin
      if (sb_p.size() != 0) e = sb_p.pop_front();
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({rd_perr, rd_ferr, rd_data} !== 10'd0) begin n_bad++; $display("FAIL reset_head: got %h want 000", {rd_perr, rd_ferr, rd_data}); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    entry_t e;
    expect_frame(1'b0, 8'h55, 1'b0, 1'b0);
    frame_head(1'b0, 8'h55, 1'b0);
    set_line(1'b0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_before_push: got %b want 0", rd_valid); end
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: got %b want 1", rd_valid); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", fifo_count); end
    e = take(1'b0);
    n_cmp++; if ({rd_perr, rd_ferr, rd_data} !== e) begin n_bad++; $display("FAIL basic_head: got %h want %h", {rd_perr, rd_ferr, rd_data}, e); end
    pop_main();
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pop_valid: got %b want 0", rd_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL basic_pop_count: got %0d want 0", fifo_count); end
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic test_false_start();
    @(posedge clk); #1;
    set_line(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 set_line(1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL false_busy_rise: got %b want 1", busy); end
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL false_busy_hold: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL false_busy_drop: got %b want 0", busy); end
    repeat (3 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL false_count: got %0d want 0", fifo_count); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL false_valid: got %b want 0", rd_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_parity();
    entry_t e;
    bit ok;
    send_frame(1'b1, 8'hA3, 1'b1, 0);
    wait_valid(1'b1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL parity_bad_timeout: got no rd_valid want 1"); end
    e = take(1'b1);
    n_cmp++; if ({rd_perr_p, rd_ferr_p, rd_data_p} !== e) begin n_bad++; $display("FAIL parity_bad_head: got %h want %h", {rd_perr_p, rd_ferr_p, rd_data_p}, e); end
    pop_par();
    send_frame(1'b1, 8'hA3, 1'b0, 0);
    wait_valid(1'b1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL parity_good_timeout: got no rd_valid want 1"); end
    e = take(1'b1);
    n_cmp++; if ({rd_perr_p, rd_ferr_p, rd_data_p} !== e) begin n_bad++; $display("FAIL parity_good_head: got %h want %h", {rd_perr_p, rd_ferr_p, rd_data_p}, e); end
    pop_par();
    @(negedge clk);
    n_cmp++; if (fifo_count_p !== 3'd0) begin n_bad++; $display("FAIL parity_count: got %0d want 0", fifo_count_p); end
    n_cmp++; if ({overrun_p, busy_p} !== 2'b00) begin n_bad++; $display("FAIL parity_idle: got %b want 00", {overrun_p, busy_p}); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_err();
    entry_t e;
    bit ok;
    send_frame(1'b0, 8'h3C, 1'b0, 12);
    send_frame(1'b0, 8'h01, 1'b0, 0);
    wait_valid(1'b0, ok);
    n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL ferr_count: got %0d want 2", fifo_count); end
    e = take(1'b0);
    n_cmp++; if ({rd_perr, rd_ferr, rd_data} !== e) begin n_bad++; $display("FAIL ferr_head: got %h want %h", {rd_perr, rd_ferr, rd_data}, e); end
    pop_main();
    @(negedge clk);
    e = take(1'b0);
    n_cmp++; if ({rd_perr, rd_ferr, rd_data} !== e) begin n_bad++; $display("FAIL ferr_resync: got %h want %h", {rd_perr, rd_ferr, rd_data}, e); end
    pop_main();
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL ferr_empty: got %b want 0", rd_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    entry_t e;
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'h10 + i), 1'b0, 0);
    @(negedge clk);
    n_cmp++; if (overrun !== exp_ovr) begin n_bad++; $display("FAIL ovr_set: got %b want %b", overrun, exp_ovr); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovr_count: got %0d want 4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = take(1'b0);
      n_cmp++; if ({rd_perr, rd_ferr, rd_data} !== e) begin n_bad++; $display("FAIL ovr_pop%0d: got %h want %h", i, {rd_perr, rd_ferr, rd_data}, e); end
      pop_main();
    end
    @(negedge clk);
    n_cmp++; if ({rd_valid, overrun} !== 2'b01) begin n_bad++; $display("FAIL ovr_drained: got %b want 01", {rd_valid, overrun}); end
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
    n_cmp++; if (overrun !== exp_ovr) begin n_bad++; $display("FAIL ovr_clear: got %b want %b", overrun, exp_ovr); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    entry_t e;
    bit ok;
    send_frame(1'b0, 8'h77, 1'b0, 0);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if ({busy, rd_valid} !== 2'b11) begin n_bad++; $display("FAIL mid_pre: got %b want 11", {busy, rd_valid}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, rd_valid, overrun} !== 3'b000) begin n_bad++; $display("FAIL mid_flags: got %b want 000", {busy, rd_valid, overrun}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
    n_cmp++; if ({rd_perr, rd_ferr, rd_data} !== 10'd0) begin n_bad++; $display("FAIL mid_head: got %h want 000", {rd_perr, rd_ferr, rd_data}); end
    sb.delete();
    sb_p.delete();
    exp_ovr = 1'b0;
    set_line(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    send_frame(1'b0, 8'h42, 1'b0, 0);
    wait_valid(1'b0, ok);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL mid_after_count: got %0d want 1", fifo_count); end
    e = take(1'b0);
    n_cmp++; if ({rd_perr, rd_ferr, rd_data} !== e) begin n_bad++; $display("FAIL mid_after_head: got %h want %h", {rd_perr, rd_ferr, rd_data}, e); end
    pop_main();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
